// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable data/parity/stop) with majority-vote sampling feeding a show-ahead FIFO.
// Entry visible 1 clk after the last stop-bit decision; when the FIFO is full and not popped, the frame is dropped and overrun set.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int EW           = DATA_BITS + 2;

  localparam logic [CW-1:0] SAMP0   = CW'(HALF - 1);
  localparam logic [CW-1:0] SAMP1   = CW'(HALF);
  localparam logic [CW-1:0] DECIDE  = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

  state_t               state;
  logic                 sync1, sync2, prev;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 perr_r, ferr_r;

  logic vote, decide, last_cnt, last_stop, exp_par, push;

  // Synchroniser and history preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign vote      = (s0 & s1) | (s0 & sync2) | (s1 & sync2);
  assign decide    = (cnt == DECIDE);
  assign last_cnt  = (cnt == CNT_MAX);
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  assign exp_par   = (PARITY == 1) ? ~(^rx_shift) : (^rx_shift);
  assign push      = (state == ST_STOP) && decide && last_stop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      rx_shift <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (state == ST_IDLE)
        cnt <= '0;
      else
        cnt <= last_cnt ? '0 : cnt + 1'b1;
      if (cnt == SAMP0) s0 <= sync2;
      if (cnt == SAMP1) s1 <= sync2;

      case (state)
        ST_IDLE: begin
          if (prev && !sync2) begin
            state    <= ST_START;
            busy     <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && vote) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (last_cnt) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide) rx_shift[bit_idx] <= vote;
          if (last_cnt) begin
            if (bit_idx == BW'(DATA_BITS - 1))
              state <= (PARITY != 0) ? ST_PAR : ST_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_PAR: begin
          if (decide) perr_r <= (vote != exp_par);
          if (last_cnt) state <= ST_STOP;
        end
        ST_STOP: begin
          // Leave on the final decision, not the bit end, so a tight next start edge is caught.
          if (decide) begin
            ferr_r <= ferr_r | ~vote;
            if (last_stop) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (last_cnt) begin
            stop_idx <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en;
  logic [EW-1:0] head;

  assign full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign pop   = rx_valid & rx_ready;
  assign wr_en = push & (~full | pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {rx_shift, perr_r, ferr_r | ~vote};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !wr_en)
        fifo_count <= fifo_count - 1'b1;
      if (push && full && !pop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  // Head fields forced to zero while empty so reset/idle outputs are clean.
  assign rx_valid = (fifo_count != '0);
  assign rx_data  = rx_valid ? head[EW-1:2] : '0;
  assign rx_perr  = rx_valid ? head[1] : 1'b0;
  assign rx_ferr  = rx_valid ? head[0] : 1'b0;

endmodule
